// File: rtl/msk_xor_acc_pkg.sv
// Shared types and helpers for the masked XOR accumulator.
package msk_xor_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } state_t;

    // Upper bound on COUNT*D supported by share0_mask.
    localparam int MASK_MAX = 1024;

    function automatic logic [MASK_MAX-1:0] share0_mask(input int count, input int d);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            if (i < count && i < count * d) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic int cnt_w(input int nterms);
        return (nterms < 1) ? 1 : $clog2(nterms + 1);
    endfunction

endpackage

// File: rtl/msk_xor_acc_ctrl.sv
// Frame control for the masked XOR accumulator: ACC/FULL state and term counter.
module msk_xor_acc_ctrl
    import msk_xor_acc_pkg::*;
#(
    parameter int NTERMS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic flush,
    input  logic out_ready,
    output logic load_first,
    output logic load_last,
    output logic in_ready,
    output logic out_valid,
    output logic out_fire
);

    localparam int CW = cnt_w(NTERMS);
    localparam logic [CW-1:0] LAST = CW'(NTERMS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          take;

    assign in_ready   = (state == ACC) | out_ready;
    // Flush wins over a same-cycle accept, but only while collecting.
    assign take       = in_valid & in_ready & ~(flush & (state == ACC));
    assign load_first = take & (cnt == '0);
    assign load_last  = take & (cnt == LAST);
    assign out_fire   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else if (state == ACC && flush) begin
            cnt <= '0;
        end else if (take) begin
            // A take in FULL implies out_fire, so the held result is gone either way.
            if (load_last) begin
                cnt       <= '0;
                state     <= FULL;
                out_valid <= 1'b1;
            end else begin
                cnt       <= cnt + 1'b1;
                state     <= ACC;
                out_valid <= 1'b0;
            end
        end else if (out_fire) begin
            state     <= ACC;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/msk_xor_acc.sv
// Masked XOR accumulator: share-wise XOR of NTERMS sharings, optional share-0 inversion.
module msk_xor_acc
    import msk_xor_acc_pkg::*;
#(
    parameter int D      = 2,
    parameter int COUNT  = 1,
    parameter int NTERMS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COUNT*D-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_inv,
    input  logic                 flush,
    output logic [COUNT*D-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = COUNT * D;
    localparam logic [W-1:0] INV_MASK = W'(share0_mask(COUNT, D));

    logic         load_first;
    logic         load_last;
    logic         out_fire;
    logic         absorb;
    logic [W-1:0] acc;
    logic [W-1:0] acc_base;

    msk_xor_acc_ctrl #(
        .NTERMS(NTERMS)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_ready (out_ready),
        .load_first(load_first),
        .load_last (load_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_fire  (out_fire)
    );

    // In FULL a term is only taken alongside the output handshake; flush is ignored there.
    assign absorb   = in_valid & in_ready & (out_valid ? out_fire : ~flush);
    assign acc_base = load_first ? '0 : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (absorb) begin
                acc <= acc_base ^ in_data;
            end
            if (load_last) begin
                out_data <= acc_base ^ in_data ^ (in_inv ? INV_MASK : '0);
            end
        end
    end

endmodule

// File: tb/tb_msk_xor_acc.sv
// Bench for msk_xor_acc: directed vectors plus random traffic against a frame-level model.
module tb_msk_xor_acc;

    logic       clk;
    logic       rst_n;

    logic [7:0] a_in_data;
    logic       a_in_valid;
    logic       a_in_ready;
    logic       a_in_inv;
    logic       a_flush;
    logic [7:0] a_out_data;
    logic       a_out_valid;
    logic       a_out_ready;

    logic [2:0] b_in_data;
    logic       b_in_valid;
    logic       b_in_ready;
    logic       b_in_inv;
    logic       b_flush;
    logic [2:0] b_out_data;
    logic       b_out_valid;
    logic       b_out_ready;

    int passed;
    int total;

    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    int         m_n;

    msk_xor_acc #(.D(2), .COUNT(4), .NTERMS(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_inv(a_in_inv), .flush(a_flush),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    msk_xor_acc #(.D(3), .COUNT(1), .NTERMS(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_inv(b_in_inv), .flush(b_flush),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        exp_q.delete();
        m_acc = '0;
        m_n   = 0;
    endtask

    // One clock of stimulus for dut_a; scores outputs and handshake against the frame model.
    task automatic cycle_a(input logic v, input logic [7:0] d, input logic inv,
                           input logic fl, input logic ordy);
        bit hold;
        bit exp_rdy;
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_inv    = inv;
        a_flush     = fl;
        a_out_ready = ordy;
        #1;
        hold    = (exp_q.size() > 0);
        exp_rdy = !hold || ordy;
        total++;
        if (hold) begin
            if (a_out_valid !== 1'b1 || a_out_data !== exp_q[0]) begin
                $display("FAIL out_result: got valid=%b data=%h expected valid=1 data=%h",
                         a_out_valid, a_out_data, exp_q[0]);
            end else passed++;
        end else begin
            if (a_out_valid !== 1'b0) begin
                $display("FAIL out_idle: got valid=%b expected valid=0", a_out_valid);
            end else passed++;
        end
        total++;
        if (a_in_ready !== exp_rdy) begin
            $display("FAIL in_ready: got %b expected %b", a_in_ready, exp_rdy);
        end else passed++;
        if (hold && ordy) void'(exp_q.pop_front());
        if (fl && !hold) begin
            m_acc = '0;
            m_n   = 0;
        end else if (v && exp_rdy) begin
            m_acc = m_acc ^ d;
            m_n++;
            if (m_n == 4) begin
                exp_q.push_back(m_acc ^ (inv ? 8'h0F : 8'h00));
                m_acc = '0;
                m_n   = 0;
            end
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || b_out_valid !== 1'b0 || b_out_data !== 3'b000) begin
            $display("FAIL %s_in_reset: got a=%b/%h b=%b/%h expected 0/00 0/0",
                     tag, a_out_valid, a_out_data, b_out_valid, b_out_data);
        end else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        #1;
        total++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            $display("FAIL %s_after_release: got a_rdy=%b b_rdy=%b a_vld=%b expected 1 1 0",
                     tag, a_in_ready, b_in_ready, a_out_valid);
        end else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_inv = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_inv = 0; b_flush = 0; b_out_ready = 1;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_in_ready !== 1'b1) begin
            $display("FAIL reset_state: got vld=%b data=%h rdy=%b expected 0 00 1",
                     a_out_valid, a_out_data, a_in_ready);
        end else passed++;
    endtask

    task automatic test_vector(input logic inv_all, input logic [7:0] expected);
        cycle_a(1, 8'h53, inv_all, 0, 1);
        cycle_a(1, 8'h01, inv_all, 0, 1);
        cycle_a(1, 8'hAF, inv_all, 0, 1);
        cycle_a(1, 8'h22, inv_all, 0, 1);
        total++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL vector_early: got valid=%b expected 0", a_out_valid);
        end else passed++;
        cycle_a(0, 8'h00, 0, 0, 1);
        total++;
        if (a_out_valid !== 1'b1 || a_out_data !== expected) begin
            $display("FAIL vector_result: got valid=%b data=%h expected 1 %h",
                     a_out_valid, a_out_data, expected);
        end else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        for (int i = 0; i < 4; i++) cycle_a(1, 8'($urandom), 0, 0, 0);
        cycle_a(1, 8'($urandom), 0, 0, 0);
        held = a_out_data;
        for (int i = 0; i < 5; i++) begin
            cycle_a(1, 8'($urandom), 0, 0, 0);
            total++;
            if (a_in_ready !== 1'b0 || a_out_data !== held) begin
                $display("FAIL backpressure_hold: got rdy=%b data=%h expected 0 %h",
                         a_in_ready, a_out_data, held);
            end else passed++;
        end
        cycle_a(1, 8'($urandom), 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle_a(1, 8'($urandom), 0, 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_flush();
        cycle_a(1, 8'h5A, 0, 0, 1);
        cycle_a(1, 8'hC3, 0, 0, 1);
        cycle_a(1, 8'h77, 0, 1, 1);
        cycle_a(1, 8'h12, 0, 0, 1);
        cycle_a(1, 8'h34, 0, 0, 1);
        cycle_a(1, 8'h56, 0, 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
        total++;
        if (a_out_valid !== 1'b0) begin
            $display("FAIL flush_count: got valid=%b expected 0", a_out_valid);
        end else passed++;
        cycle_a(1, 8'h78, 0, 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
        total++;
        if (a_out_valid !== 1'b1 || a_out_data !== 8'h08) begin
            $display("FAIL flush_result: got valid=%b data=%h expected 1 08",
                     a_out_valid, a_out_data);
        end else passed++;
        cycle_a(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_single_term();
        logic [2:0] prev_d;
        logic       prev_inv;
        logic [2:0] exp_d;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            #1;
            if (i > 0) begin
                exp_d = prev_d ^ {2'b00, prev_inv};
                total++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_d || b_in_ready !== 1'b1) begin
                    $display("FAIL single_term: got vld=%b data=%b rdy=%b expected 1 %b 1",
                             b_out_valid, b_out_data, b_in_ready, exp_d);
                end else passed++;
            end
            prev_d     = 3'($urandom);
            prev_inv   = 1'($urandom);
            b_in_valid = 1'b1;
            b_in_data  = prev_d;
            b_in_inv   = prev_inv;
            b_out_ready = 1'b1;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        exp_d = prev_d ^ {2'b00, prev_inv};
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== exp_d) begin
            $display("FAIL single_term_last: got vld=%b data=%b expected 1 %b",
                     b_out_valid, b_out_data, exp_d);
        end else passed++;
        @(negedge clk);
        #1;
        total++;
        if (b_out_valid !== 1'b0) begin
            $display("FAIL single_term_drain: got vld=%b expected 0", b_out_valid);
        end else passed++;
    endtask

    task automatic test_reset_mid();
        cycle_a(1, 8'hE1, 0, 0, 1);
        cycle_a(1, 8'h3C, 0, 0, 1);
        pulse_reset("reset_mid_frame");
        for (int i = 0; i < 4; i++) cycle_a(1, 8'($urandom), 1'($urandom), 0, 0);
        cycle_a(0, 8'h00, 0, 0, 0);
        pulse_reset("reset_full");
        for (int i = 0; i < 4; i++) cycle_a(1, 8'($urandom), 1'($urandom), 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
        cycle_a(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle_a(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cycle_a(0, 8'h00, 0, 0, 1);
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL random_drain: got %0d pending results expected 0", exp_q.size());
        end else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_vector(1'b0, 8'hDF);
        test_vector(1'b1, 8'hD0);
        cycle_a(0, 8'h00, 0, 0, 1);
        test_backpressure();
        test_flush();
        test_single_term();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
